dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 32 +++
 rtl/dmem_lane_align.sv | 76 +++++++
 rtl/dmem_responder.sv | 133 +++++++++++++
 tb/tb_dmem_responder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared encodings, FSM state type and defaults for the data
//                memory responder.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

    localparam int unsigned DMEM_DEPTH_WORDS = 1024;
    localparam int unsigned DMEM_LATENCY     = 2;

    localparam logic [1:0] WSEL_BYTE = 2'b00;
    localparam logic [1:0] WSEL_HALF = 2'b01;
    localparam logic [1:0] WSEL_WORD = 2'b10;

    localparam logic [2:0] RSEL_LB  = 3'b000;
    localparam logic [2:0] RSEL_LH  = 3'b001;
    localparam logic [2:0] RSEL_LW  = 3'b010;
    localparam logic [2:0] RSEL_LBU = 3'b100;
    localparam logic [2:0] RSEL_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

endpackage

`default_nettype wire

// File: rtl/dmem_lane_align.sv
// ============================================================================
//  Module      : dmem_lane_align
//  Description : Byte-enable / store-lane replication and load extraction
//                with sign or zero extension; flags misaligned or reserved ops.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic        we_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  wsel_i,
    input  logic [2:0]  rsel_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        fmt_err_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = rword_i[{addr_lo_i, 3'b000} +: 8];
    assign w_half = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];

    always_comb begin
        be_o      = 4'b0000;
        wdata_o   = wdata_i;
        rdata_o   = rword_i;
        fmt_err_o = 1'b0;
        if (we_i) begin
            // Narrow stores are replicated across lanes; byte enables pick the target.
            case (wsel_i)
                WSEL_BYTE: begin
                    be_o    = 4'b0001 << addr_lo_i;
                    wdata_o = {4{wdata_i[7:0]}};
                end
                WSEL_HALF: begin
                    be_o      = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                    wdata_o   = {2{wdata_i[15:0]}};
                    fmt_err_o = addr_lo_i[0];
                end
                WSEL_WORD: begin
                    be_o      = 4'b1111;
                    fmt_err_o = |addr_lo_i;
                end
                default: fmt_err_o = 1'b1;
            endcase
        end else begin
            case (rsel_i)
                RSEL_LB:  rdata_o = {{24{w_byte[7]}}, w_byte};
                RSEL_LBU: rdata_o = {24'd0, w_byte};
                RSEL_LH: begin
                    rdata_o   = {{16{w_half[15]}}, w_half};
                    fmt_err_o = addr_lo_i[0];
                end
                RSEL_LHU: begin
                    rdata_o   = {16'd0, w_half};
                    fmt_err_o = addr_lo_i[0];
                end
                RSEL_LW:  fmt_err_o = |addr_lo_i;
                default: begin
                    rdata_o   = '0;
                    fmt_err_o = 1'b1;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
//  Module      : dmem_responder
//  Description : Single-outstanding data memory with fixed response latency,
//                byte/half/word stores and extended loads.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DMEM_DEPTH_WORDS,
    parameter int unsigned LATENCY     = DMEM_LATENCY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_wsel,
    input  logic [2:0]  req_rsel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int unsigned c_IDX_W  = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  c_LAT_M1 = 4'(LATENCY - 1);

    logic [31:0] mem_q [DEPTH_WORDS];

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic               w_accept;
    logic               w_range_err;
    logic               w_fmt_err;
    logic               w_err;
    logic [c_IDX_W-1:0] w_idx;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata;
    logic [31:0]        w_rdata;

    assign req_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;

    assign w_accept    = req_valid && req_ready;
    assign w_idx       = req_addr[c_IDX_W+1:2];
    assign w_range_err = (req_addr[31:2] >= 30'(DEPTH_WORDS));
    assign w_err       = w_range_err || w_fmt_err;

    dmem_lane_align u_lane_align (
        .we_i      (req_we),
        .addr_lo_i (req_addr[1:0]),
        .wsel_i    (req_wsel),
        .rsel_i    (req_rsel),
        .wdata_i   (req_wdata),
        .rword_i   (mem_q[w_idx]),
        .be_o      (w_be),
        .wdata_o   (w_wdata),
        .rdata_o   (w_rdata),
        .fmt_err_o (w_fmt_err)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    // Load data is captured now so later stores cannot alter it.
                    cnt_d   = c_LAT_M1;
                    state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
                    err_d   = w_err;
                    rdata_d = (req_we || w_err) ? 32'd0 : w_rdata;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Array contents survive reset; stores commit on the accept edge.
    always_ff @(posedge clk) begin
        if (rst && w_accept && req_we && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    mem_q[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Directed and randomized checks of dmem_responder against a
//                byte-array reference model; second instance built with LATENCY=1.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dmem_responder;

    localparam int unsigned LAT_A = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_wsel;
    logic [2:0]  req_rsel;
    logic        rsp_valid, rsp_ready, rsp_err, busy;
    logic [31:0] rsp_rdata;

    logic        b_req_valid, b_req_ready, b_req_we;
    logic [31:0] b_req_addr, b_req_wdata;
    logic [1:0]  b_req_wsel;
    logic [2:0]  b_req_rsel;
    logic        b_rsp_valid, b_rsp_ready, b_rsp_err, b_busy;
    logic [31:0] b_rsp_rdata;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    logic [7:0] mb [64];

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT_A)) u_dut_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wsel(req_wsel),
        .req_rsel(req_rsel), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_wsel(b_req_wsel),
        .req_rsel(b_req_rsel), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err), .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Access size in bytes from the encoding; 0 marks a reserved encoding.
    function automatic int op_size(input bit we, input logic [1:0] wsel, input logic [2:0] rsel);
        if (we) begin
            case (wsel)
                2'd0: return 1;
                2'd1: return 2;
                2'd2: return 4;
                default: return 0;
            endcase
        end
        case (rsel)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    task automatic model_op(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [1:0] wsel, input logic [2:0] rsel,
                            output logic [31:0] exp_rdata, output bit exp_err);
        int sz;
        logic [31:0] v;
        sz = op_size(we, wsel, rsel);
        exp_err = 1'b0;
        exp_rdata = 32'd0;
        if (sz == 0) exp_err = 1'b1;
        else if ((addr % sz) != 0) exp_err = 1'b1;
        else if (addr >= 32'd4096) exp_err = 1'b1;
        if (!exp_err) begin
            if (we) begin
                for (int i = 0; i < sz; i++) mb[addr + i] = wdata[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < sz; i++) v = v | (32'(mb[addr + i]) << (8 * i));
                if (!rsel[2] && sz < 4 && v[8*sz-1]) v = v | ~((32'd1 << (8 * sz)) - 32'd1);
                exp_rdata = v;
            end
        end
    endtask

    // Drive an ignored request while the DUT is busy.
    task automatic garble();
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'($urandom_range(0, 15)) << 2;
        req_wdata = $urandom;
        req_wsel  = 2'b10;
        req_rsel  = 3'b010;
    endtask

    task automatic access(input string tag, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] wsel, input logic [2:0] rsel,
                          input logic [31:0] exp_rdata, input bit exp_err, input int hold);
        int lat;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        req_wsel = wsel; req_rsel = rsel; rsp_ready = 1'b0;
        lat = 0;
        while (!req_ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        garble();
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            garble();
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(LAT_A));
        chk({tag, "_rdata"}, rsp_rdata, exp_rdata);
        chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            garble();
            chk({tag, "_hold_valid"}, {31'd0, rsp_valid}, 32'd1);
            chk({tag, "_hold_rdata"}, rsp_rdata, exp_rdata);
            chk({tag, "_hold_ready"}, {31'd0, req_ready}, 32'd0);
            chk({tag, "_hold_busy"}, {31'd0, busy}, 32'd1);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        chk({tag, "_done_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_done_ready"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] r_addr, r_wdata, e_rdata;
        logic [1:0]  r_wsel;
        logic [2:0]  r_rsel;
        bit          r_we, e_err;
        int          k, r, last_acc;
        logic [31:0] b_exp_rdata [4];
        logic        b_exp_err [4];

        rst = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        req_wsel = 2'd0; req_rsel = 3'd0; rsp_ready = 1'b0;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = 32'd0; b_req_wdata = 32'd0;
        b_req_wsel = 2'd0; b_req_rsel = 3'd0; b_rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_b_ready", {31'd0, b_req_ready}, 32'd1);
        rst = 1'b1;

        access("sw_dead", 1, 32'h10, 32'hDEADBEEF, 2'b10, 3'b010, 32'd0, 0, 0);
        access("lw_dead", 0, 32'h10, 32'd0, 2'b10, 3'b010, 32'hDEADBEEF, 0, 0);
        access("sw_base", 1, 32'h10, 32'h11223344, 2'b10, 3'b010, 32'd0, 0, 0);
        access("sb_80", 1, 32'h13, 32'h00000080, 2'b00, 3'b010, 32'd0, 0, 0);
        access("lb_13", 0, 32'h13, 32'd0, 2'b00, 3'b000, 32'hFFFFFF80, 0, 0);
        access("lbu_13", 0, 32'h13, 32'd0, 2'b00, 3'b100, 32'h00000080, 0, 0);
        access("lw_10", 0, 32'h10, 32'd0, 2'b10, 3'b010, 32'h80223344, 0, 0);
        access("lh_mis", 0, 32'h0B, 32'd0, 2'b01, 3'b001, 32'd0, 1, 0);
        access("sw_mis", 1, 32'h12, 32'hCAFEF00D, 2'b10, 3'b010, 32'd0, 1, 0);
        access("sw_rsvd", 1, 32'h10, 32'hCAFEF00D, 2'b11, 3'b010, 32'd0, 1, 0);
        access("lw_rsvd", 0, 32'h10, 32'd0, 2'b10, 3'b011, 32'd0, 1, 0);
        access("lw_oor", 0, 32'h1000, 32'd0, 2'b10, 3'b010, 32'd0, 1, 0);
        access("lw_keep", 0, 32'h10, 32'd0, 2'b10, 3'b010, 32'h80223344, 0, 5);

        // Reset in the cycle after a store accept: no response, store persists.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h0BADC0DE;
        req_wsel = 2'b10; req_rsel = 3'b010;
        chk("rstmid_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rstmid_novalid", {31'd0, rsp_valid}, 32'd0);
        end
        access("rstmid_lw", 0, 32'h20, 32'd0, 2'b10, 3'b010, 32'h0BADC0DE, 0, 0);

        // Randomized phase over the first 16 words.
        for (int w = 0; w < 16; w++) begin
            r_wdata = $urandom;
            model_op(1, 32'(w * 4), r_wdata, 2'b10, 3'b010, e_rdata, e_err);
            access("init", 1, 32'(w * 4), r_wdata, 2'b10, 3'b010, e_rdata, e_err, 0);
        end
        for (int n = 0; n < 60; n++) begin
            r_we = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 7) == 0) r_addr = 32'h1000 + 32'($urandom_range(0, 255));
            else begin
                r_addr = 32'($urandom_range(0, 63));
                if ($urandom_range(0, 1) == 1) r_addr = r_addr & ~32'h3;
            end
            r_wdata = $urandom;
            r_wsel = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0: r_rsel = 3'($urandom_range(0, 7));
                1, 2: r_rsel = 3'b010;
                3: r_rsel = 3'b000;
                4: r_rsel = 3'b001;
                5: r_rsel = 3'b100;
                default: r_rsel = 3'b101;
            endcase
            model_op(r_we, r_addr, r_wdata, r_wsel, r_rsel, e_rdata, e_err);
            access("rand", r_we, r_addr, r_wdata, r_wsel, r_rsel, e_rdata, e_err,
                   int'($urandom_range(0, 2)));
        end

        // LATENCY=1 instance: continuous requests with rsp_ready tied high.
        b_exp_rdata[0] = 32'd0;        b_exp_err[0] = 1'b0;
        b_exp_rdata[1] = 32'h5A5AA5A5; b_exp_err[1] = 1'b0;
        b_exp_rdata[2] = 32'd0;        b_exp_err[2] = 1'b1;
        b_exp_rdata[3] = 32'hFFFFFFA5; b_exp_err[3] = 1'b0;
        b_rsp_ready = 1'b1;
        k = 0; r = 0; last_acc = -1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (b_rsp_valid && r < 4) begin
                chk("l1_rsp_cyc", 32'(cyc - last_acc), 32'd1);
                chk("l1_rdata", b_rsp_rdata, b_exp_rdata[r]);
                chk("l1_err", {31'd0, b_rsp_err}, {31'd0, b_exp_err[r]});
                r++;
            end
            b_req_valid = (k < 4);
            case (k)
                0: begin b_req_we = 1'b1; b_req_addr = 32'h0; b_req_wdata = 32'h5A5AA5A5;
                         b_req_wsel = 2'b10; b_req_rsel = 3'b010; end
                1: begin b_req_we = 1'b0; b_req_addr = 32'h0; b_req_rsel = 3'b010; end
                2: begin b_req_we = 1'b0; b_req_addr = 32'h1000; b_req_rsel = 3'b010; end
                default: begin b_req_we = 1'b0; b_req_addr = 32'h1; b_req_rsel = 3'b000; end
            endcase
            if (b_req_valid && b_req_ready) begin
                if (last_acc >= 0) chk("l1_spacing", 32'(cyc - last_acc), 32'd2);
                last_acc = cyc;
                k++;
            end
        end
        b_req_valid = 1'b0;
        chk("l1_accepts", 32'(k), 32'd4);
        chk("l1_rsps", 32'(r), 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
